// File: rtl/life_pkg.sv
// -----------------------------------------------------------------------------
// life_pkg
// Shared definitions for the neighbour scan: neighbour count, the neighbour
// index enumeration in scan order (NW, N, NE, W, E, SW, S, SE), the per-index
// x/y offsets, and the Game-of-Life next-state rule used by the optional
// rule output of nbr_scan_counter.
// -----------------------------------------------------------------------------
package life_pkg;

    localparam int NEIGHBOURS_CNT = 8;

    typedef enum logic [2:0] {
        NB_NW = 3'd0,
        NB_N  = 3'd1,
        NB_NE = 3'd2,
        NB_W  = 3'd3,
        NB_E  = 3'd4,
        NB_SW = 3'd5,
        NB_S  = 3'd6,
        NB_SE = 3'd7
    } nb_idx_e;

    // Offsets indexed by nb_idx_e; y grows downwards (N is y-1).
    localparam logic signed [1:0] NB_DX [NEIGHBOURS_CNT] =
        '{-2'sd1, 2'sd0, 2'sd1, -2'sd1, 2'sd1, -2'sd1, 2'sd0, 2'sd1};
    localparam logic signed [1:0] NB_DY [NEIGHBOURS_CNT] =
        '{-2'sd1, -2'sd1, -2'sd1, 2'sd0, 2'sd0, 2'sd1, 2'sd1, 2'sd1};

    // Birth on exactly 3 live neighbours, survival on 2 or 3.
    function automatic logic life_next_state(input logic [3:0] cnt, input logic alive);
        return (cnt == 4'd3) || ((cnt == 4'd2) && alive);
    endfunction

endpackage

// File: rtl/nbr_adr_calc.sv
// -----------------------------------------------------------------------------
// nbr_adr_calc
// Combinational neighbour address generator: maps a target cell and a
// neighbour index to the neighbour's coordinates and whether that neighbour
// exists on the field.
//   TORUS = 0 : off-field neighbours are flagged not relevant (address is
//               don't-care in that case).
//   TORUS = 1 : every neighbour is relevant; coordinates wrap at FIELD_W /
//               FIELD_H (not at the power of two of the address width).
// Ports:
//   i_cell_x_adr / i_cell_y_adr : target cell coordinates
//   i_idx                       : neighbour index (nb_idx_e order)
//   o_x_adr / o_y_adr           : neighbour coordinates
//   o_relevant                  : neighbour lies on the field (always 1 on torus)
// -----------------------------------------------------------------------------
module nbr_adr_calc
    import life_pkg::*;
#(
    parameter int FIELD_W    = 4,
    parameter int FIELD_H    = 3,
    parameter int TORUS      = 0,
    parameter int X_ADR_SIZE = (FIELD_W > 1) ? $clog2(FIELD_W) : 1,
    parameter int Y_ADR_SIZE = (FIELD_H > 1) ? $clog2(FIELD_H) : 1
) (
    input  logic [X_ADR_SIZE-1:0] i_cell_x_adr,
    input  logic [Y_ADR_SIZE-1:0] i_cell_y_adr,
    input  logic [2:0]            i_idx,
    output logic [X_ADR_SIZE-1:0] o_x_adr,
    output logic [Y_ADR_SIZE-1:0] o_y_adr,
    output logic                  o_relevant
);

    localparam logic [X_ADR_SIZE-1:0] X_MAX = X_ADR_SIZE'(FIELD_W - 1);
    localparam logic [Y_ADR_SIZE-1:0] Y_MAX = Y_ADR_SIZE'(FIELD_H - 1);

    logic signed [1:0] w_dx;
    logic signed [1:0] w_dy;
    logic              w_x_lo;
    logic              w_x_hi;
    logic              w_y_lo;
    logic              w_y_hi;
    logic              w_x_off;
    logic              w_y_off;

    always_comb begin
        // NOTE: every signal written here gets a value on every path (defaults
        // first), so no latch can be inferred.
        w_dx    = NB_DX[i_idx];
        w_dy    = NB_DY[i_idx];
        w_x_lo  = (i_cell_x_adr == '0);
        w_x_hi  = (i_cell_x_adr >= X_MAX);
        w_y_lo  = (i_cell_y_adr == '0);
        w_y_hi  = (i_cell_y_adr >= Y_MAX);
        o_x_adr = i_cell_x_adr;
        o_y_adr = i_cell_y_adr;

        // Negative offset: sign bit set. Edge cases wrap explicitly to MAX / 0.
        if (w_dx[1]) begin
            o_x_adr = w_x_lo ? X_MAX : i_cell_x_adr - X_ADR_SIZE'(1);
        end else if (w_dx == 2'sd1) begin
            o_x_adr = w_x_hi ? '0 : i_cell_x_adr + X_ADR_SIZE'(1);
        end

        if (w_dy[1]) begin
            o_y_adr = w_y_lo ? Y_MAX : i_cell_y_adr - Y_ADR_SIZE'(1);
        end else if (w_dy == 2'sd1) begin
            o_y_adr = w_y_hi ? '0 : i_cell_y_adr + Y_ADR_SIZE'(1);
        end

        w_x_off    = (w_dx[1] && w_x_lo) || ((w_dx == 2'sd1) && w_x_hi);
        w_y_off    = (w_dy[1] && w_y_lo) || ((w_dy == 2'sd1) && w_y_hi);
        o_relevant = (TORUS != 0) || !(w_x_off || w_y_off);
    end

endmodule

// File: rtl/nbr_scan_counter.sv
// -----------------------------------------------------------------------------
// nbr_scan_counter
// Walks the 8 neighbours of one target cell (NW, N, NE, W, E, SW, S, SE),
// reads each relevant neighbour from field memory over a req/ready + rvalid
// handshake (one read outstanding at most), accumulates the live count and
// pulses o_done for one cycle when the count is final.
// Optional feature, macro NBR_SCAN_LIFE_RULE_EN: adds i_cell_alive (latched on
// start) and registered o_next_alive, updated together with o_done.
// Ports:
//   i_clk, i_rst_n                : clock, async active-low reset
//   i_start, i_cell_x/y_adr       : start request and target cell (IDLE only)
//   o_mem_req, o_mem_x/y_adr      : read request and neighbour address
//   i_mem_ready                   : request accepted this cycle
//   i_mem_rvalid, i_mem_rdata     : read response (rdata 1 = alive)
//   o_busy                        : scan in progress
//   o_done                        : one-cycle pulse, o_alive_cnt final
//   o_alive_cnt                   : live neighbours, cleared on accepted start
// -----------------------------------------------------------------------------
module nbr_scan_counter
    import life_pkg::*;
#(
    parameter int FIELD_W    = 4,
    parameter int FIELD_H    = 3,
    parameter int TORUS      = 0,
    parameter int X_ADR_SIZE = (FIELD_W > 1) ? $clog2(FIELD_W) : 1,
    parameter int Y_ADR_SIZE = (FIELD_H > 1) ? $clog2(FIELD_H) : 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic [X_ADR_SIZE-1:0] i_cell_x_adr,
    input  logic [Y_ADR_SIZE-1:0] i_cell_y_adr,
    output logic                  o_mem_req,
    output logic [X_ADR_SIZE-1:0] o_mem_x_adr,
    output logic [Y_ADR_SIZE-1:0] o_mem_y_adr,
    input  logic                  i_mem_ready,
    input  logic                  i_mem_rvalid,
    input  logic                  i_mem_rdata,
    output logic                  o_busy,
    output logic                  o_done,
`ifdef NBR_SCAN_LIFE_RULE_EN
    input  logic                  i_cell_alive,
    output logic                  o_next_alive,
`endif
    output logic [3:0]            o_alive_cnt
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SCAN = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]            r_state;
    logic [2:0]            r_idx;
    logic [X_ADR_SIZE-1:0] r_cell_x;
    logic [Y_ADR_SIZE-1:0] r_cell_y;
    logic [3:0]            r_cnt;

    logic [X_ADR_SIZE-1:0] w_nb_x;
    logic [Y_ADR_SIZE-1:0] w_nb_y;
    logic                  w_relevant;
    logic                  w_last;
    logic                  w_skip;
    logic                  w_rd_done;
    logic [3:0]            w_cnt_nxt;

    nbr_adr_calc #(
        .FIELD_W    (FIELD_W),
        .FIELD_H    (FIELD_H),
        .TORUS      (TORUS),
        .X_ADR_SIZE (X_ADR_SIZE),
        .Y_ADR_SIZE (Y_ADR_SIZE)
    ) u_adr_calc (
        .i_cell_x_adr (r_cell_x),
        .i_cell_y_adr (r_cell_y),
        .i_idx        (r_idx),
        .o_x_adr      (w_nb_x),
        .o_y_adr      (w_nb_y),
        .o_relevant   (w_relevant)
    );

    always_comb begin
        w_last    = (r_idx == NB_SE);
        w_skip    = (r_state == S_SCAN) && !w_relevant;
        w_rd_done = (r_state == S_WAIT) && i_mem_rvalid;
        w_cnt_nxt = w_rd_done ? r_cnt + {3'b000, i_mem_rdata} : r_cnt;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // in the block samples pre-edge values regardless of statement order.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= S_IDLE;
            r_idx    <= '0;
            r_cell_x <= '0;
            r_cell_y <= '0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_cell_x <= i_cell_x_adr;
                        r_cell_y <= i_cell_y_adr;
                        r_idx    <= '0;
                        r_cnt    <= '0;
                        r_state  <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    // Relevant: hold request until accepted. Not relevant: one
                    // skip cycle, no request.
                    if (w_relevant) begin
                        if (i_mem_ready) begin
                            r_state <= S_WAIT;
                        end
                    end else if (w_last) begin
                        r_state <= S_DONE;
                    end else begin
                        r_idx <= r_idx + 3'd1;
                    end
                end
                S_WAIT: begin
                    if (i_mem_rvalid) begin
                        r_cnt <= w_cnt_nxt;
                        if (w_last) begin
                            r_state <= S_DONE;
                        end else begin
                            r_idx   <= r_idx + 3'd1;
                            r_state <= S_SCAN;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Addresses are forced to 0 whenever no request is issued so idle and
    // reset present a clean bus.
    always_comb begin
        o_mem_req   = (r_state == S_SCAN) && w_relevant;
        o_mem_x_adr = o_mem_req ? w_nb_x : '0;
        o_mem_y_adr = o_mem_req ? w_nb_y : '0;
        o_busy      = (r_state == S_SCAN) || (r_state == S_WAIT);
        o_done      = (r_state == S_DONE);
        o_alive_cnt = r_cnt;
    end

`ifdef NBR_SCAN_LIFE_RULE_EN
    logic r_cell_alive;
    logic r_next_alive;
    logic w_to_done;

    assign w_to_done = (w_skip || w_rd_done) && w_last;

    // Evaluated on the edge that enters DONE, from the final count, so the
    // result is valid in the same cycle as o_done.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cell_alive <= 1'b0;
            r_next_alive <= 1'b0;
        end else begin
            if ((r_state == S_IDLE) && i_start) begin
                r_cell_alive <= i_cell_alive;
            end
            if (w_to_done) begin
                r_next_alive <= life_next_state(w_cnt_nxt, r_cell_alive);
            end
        end
    end

    assign o_next_alive = r_next_alive;
`else
    // w_skip only feeds the rule output; keep it referenced in this build.
    logic w_unused;
    assign w_unused = w_skip;
`endif

endmodule

// File: tb/tb_nbr_scan_counter.sv
// -----------------------------------------------------------------------------
// tb_nbr_scan_counter
// Two instances on a 4x3 field: bounded (TORUS=0) and toroidal (TORUS=1).
// They share the memory handshake inputs; only the selected one is started.
// A memory responder serves reads from a random field, with optional ready
// stalls, delayed rvalid and spurious rvalid. Expected request order, count
// and latency come from a coordinate-arithmetic model of the neighbourhood.
// -----------------------------------------------------------------------------
module tb_nbr_scan_counter;

    localparam int W = 4;
    localparam int H = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_b = 1'b0;
    logic       start_t = 1'b0;
    logic [1:0] cell_x = '0;
    logic [1:0] cell_y = '0;
    logic       cell_alive = 1'b0;
    logic       ready = 1'b0;
    logic       rvalid = 1'b0;
    logic       rdata = 1'b0;

    logic       req_b, req_t, busy_b, busy_t, done_b, done_t;
    logic [1:0] xa_b, ya_b, xa_t, ya_t;
    logic [3:0] cnt_b, cnt_t;
    logic       next_b, next_t;

    always #5 clk = ~clk;

    nbr_scan_counter #(.FIELD_W(W), .FIELD_H(H), .TORUS(0)) u_dut_bnd (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start_b),
        .i_cell_x_adr(cell_x), .i_cell_y_adr(cell_y),
        .o_mem_req(req_b), .o_mem_x_adr(xa_b), .o_mem_y_adr(ya_b),
        .i_mem_ready(ready), .i_mem_rvalid(rvalid), .i_mem_rdata(rdata),
        .o_busy(busy_b), .o_done(done_b),
`ifdef NBR_SCAN_LIFE_RULE_EN
        .i_cell_alive(cell_alive), .o_next_alive(next_b),
`endif
        .o_alive_cnt(cnt_b)
    );

    nbr_scan_counter #(.FIELD_W(W), .FIELD_H(H), .TORUS(1)) u_dut_tor (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start_t),
        .i_cell_x_adr(cell_x), .i_cell_y_adr(cell_y),
        .o_mem_req(req_t), .o_mem_x_adr(xa_t), .o_mem_y_adr(ya_t),
        .i_mem_ready(ready), .i_mem_rvalid(rvalid), .i_mem_rdata(rdata),
        .o_busy(busy_t), .o_done(done_t),
`ifdef NBR_SCAN_LIFE_RULE_EN
        .i_cell_alive(cell_alive), .o_next_alive(next_t),
`endif
        .o_alive_cnt(cnt_t)
    );

`ifndef NBR_SCAN_LIFE_RULE_EN
    assign next_b = 1'b0;
    assign next_t = 1'b0;
`endif

    // Selected-instance view
    bit         sel = 1'b0;
    logic       m_req, m_busy, m_done, m_next;
    logic [1:0] m_x, m_y;
    logic [3:0] m_cnt;
    always_comb begin
        m_req  = sel ? req_t  : req_b;
        m_x    = sel ? xa_t   : xa_b;
        m_y    = sel ? ya_t   : ya_b;
        m_busy = sel ? busy_t : busy_b;
        m_done = sel ? done_t : done_b;
        m_cnt  = sel ? cnt_t  : cnt_b;
        m_next = sel ? next_t : next_b;
    end

    int n_checks = 0;
    int n_errors = 0;

    // Field contents and model outputs
    bit mem [W][H];
    int exp_x[$], exp_y[$];
    int exp_cnt, exp_lat;

    // Responder state / observed request log
    int log_x[$], log_y[$];
    int pend = 0, cur_delay = 1, req_num = 0;
    int stall_req = -1, stall_left = 0, stall_delay = 1, stab_err = 0;
    bit spurious = 0, acc_prev = 0, stalled_prev = 0;
    int lx = 0, ly = 0, px = 0, py = 0;

    // Observations of one scan
    int obs_lat, obs_cnt, obs_cnt2;
    bit obs_busy, obs_done2, obs_busy2, obs_next, obs_next2;

    initial begin
        forever begin
            @(negedge clk);
            rvalid = 1'b0;
            rdata  = 1'b0;
            ready  = 1'b0;
            if (!rst_n) begin
                pend = 0; acc_prev = 0; stalled_prev = 0;
            end else begin
                if (acc_prev) begin
                    pend = cur_delay;
                    acc_prev = 0;
                end
                if (pend > 0) begin
                    pend--;
                    if (pend == 0) begin
                        rvalid = 1'b1;
                        rdata  = mem[lx][ly];
                    end
                end
                if (stalled_prev && (!m_req || int'(m_x) != px || int'(m_y) != py)) stab_err++;
                stalled_prev = 0;
                if (m_req) begin
                    if (req_num == stall_req && stall_left > 0) begin
                        stall_left--;
                        stalled_prev = 1;
                        px = int'(m_x);
                        py = int'(m_y);
                        if (spurious) begin
                            rvalid = 1'b1;
                            rdata  = 1'b1;
                        end
                    end else begin
                        ready = 1'b1;
                        acc_prev = 1;
                        lx = int'(m_x);
                        ly = int'(m_y);
                        log_x.push_back(lx);
                        log_y.push_back(ly);
                        cur_delay = (req_num == stall_req) ? stall_delay : 1;
                        req_num++;
                    end
                end
            end
        end
    end

    // Neighbours in row-major order around (x,y); latency = 1 (done cycle)
    // + 2 per read + 1 per off-field neighbour.
    task automatic build_model(input bit torus, input int x, input int y);
        exp_x.delete();
        exp_y.delete();
        exp_cnt = 0;
        exp_lat = 1;
        for (int dy = -1; dy <= 1; dy++) begin
            for (int dx = -1; dx <= 1; dx++) begin
                int nx, ny;
                if (dx == 0 && dy == 0) continue;
                nx = x + dx;
                ny = y + dy;
                if (torus) begin
                    nx = (nx + W) % W;
                    ny = (ny + H) % H;
                end
                if (nx < 0 || nx >= W || ny < 0 || ny >= H) begin
                    exp_lat += 1;
                end else begin
                    exp_x.push_back(nx);
                    exp_y.push_back(ny);
                    exp_cnt += int'(mem[nx][ny]);
                    exp_lat += 2;
                end
            end
        end
    endtask

    task automatic fill_mem(input int mode);  // 0 all dead, 1 all alive, 2 random
        for (int i = 0; i < W; i++)
            for (int j = 0; j < H; j++)
                mem[i][j] = (mode == 2) ? bit'($urandom_range(0, 1)) : bit'(mode);
    endtask

    function automatic bit order_ok();
        if (log_x.size() != exp_x.size()) return 1'b0;
        foreach (log_x[i])
            if (log_x[i] != exp_x[i] || log_y[i] != exp_y[i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic string q_str(input bit use_log);
        string s = "";
        int n = use_log ? log_x.size() : exp_x.size();
        for (int i = 0; i < n && i < 12; i++)
            s = {s, use_log ? $sformatf("(%0d,%0d)", log_x[i], log_y[i])
                            : $sformatf("(%0d,%0d)", exp_x[i], exp_y[i])};
        return s;
    endfunction

    // Drive one scan; record latency (negedges after the start edge until
    // o_done is seen), count, and state one cycle later.
    task automatic do_scan(input bit s, input int x, input int y, input bit alive, input bit extra);
        sel = s;
        log_x.delete();
        log_y.delete();
        req_num  = 0;
        stab_err = 0;
        @(negedge clk);
        cell_x = 2'(x);
        cell_y = 2'(y);
        cell_alive = alive;
        if (s) start_t = 1'b1; else start_b = 1'b1;
        @(posedge clk);
        #1;
        start_t = 1'b0;
        start_b = 1'b0;
        obs_lat  = 0;
        obs_busy = 1'b0;
        while (1) begin
            @(negedge clk);
            obs_lat++;
            if (obs_lat == 1) obs_busy = m_busy;
            if (extra && obs_lat == 3) begin
                cell_x = ~cell_x;
                if (s) start_t = 1'b1; else start_b = 1'b1;
            end else if (extra && obs_lat == 4) begin
                start_t = 1'b0;
                start_b = 1'b0;
            end
            if (m_done || obs_lat >= 300) break;
        end
        obs_cnt  = int'(m_cnt);
        obs_next = m_next;
        @(negedge clk);
        obs_done2 = m_done;
        obs_busy2 = m_busy;
        obs_cnt2  = int'(m_cnt);
        obs_next2 = m_next;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({req_b, req_t} !== 2'b00) begin n_errors++; $display("FAIL reset_req: got %b expected 00", {req_b, req_t}); end
        n_checks++;
        if ({xa_b, ya_b, xa_t, ya_t} !== 8'h00) begin n_errors++; $display("FAIL reset_adr: got %h expected 00", {xa_b, ya_b, xa_t, ya_t}); end
        n_checks++;
        if ({busy_b, busy_t, done_b, done_t} !== 4'b0000) begin n_errors++; $display("FAIL reset_busy_done: got %b expected 0000", {busy_b, busy_t, done_b, done_t}); end
        n_checks++;
        if ({cnt_b, cnt_t} !== 8'h00) begin n_errors++; $display("FAIL reset_cnt: got %h expected 00", {cnt_b, cnt_t}); end
        n_checks++;
        if ({next_b, next_t} !== 2'b00) begin n_errors++; $display("FAIL reset_next: got %b expected 00", {next_b, next_t}); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_interior();
        fill_mem(1);
        stall_req = -1;
        build_model(1'b0, 1, 1);
        do_scan(1'b0, 1, 1, 1'b0, 1'b0);
        n_checks++;
        if (obs_busy !== 1'b1) begin n_errors++; $display("FAIL interior_busy: got %b expected 1", obs_busy); end
        n_checks++;
        if (!order_ok()) begin n_errors++; $display("FAIL interior_order: got %s expected %s", q_str(1), q_str(0)); end
        n_checks++;
        if (obs_cnt != 8) begin n_errors++; $display("FAIL interior_cnt: got %0d expected 8", obs_cnt); end
        n_checks++;
        if (obs_lat != 17) begin n_errors++; $display("FAIL interior_latency: got %0d expected 17", obs_lat); end
        n_checks++;
        if (obs_done2 !== 1'b0 || obs_busy2 !== 1'b0) begin n_errors++; $display("FAIL interior_done_pulse: done=%b busy=%b expected 0 0", obs_done2, obs_busy2); end
        n_checks++;
        if (obs_cnt2 != 8) begin n_errors++; $display("FAIL interior_cnt_hold: got %0d expected 8", obs_cnt2); end
    endtask

    task automatic test_bounded_corners();
        int cx[2] = '{0, 3};
        int cy[2] = '{0, 2};
        int ex[2][3] = '{'{1, 0, 1}, '{2, 3, 2}};
        int ey[2][3] = '{'{0, 1, 1}, '{1, 1, 2}};
        fill_mem(1);
        stall_req = -1;
        for (int k = 0; k < 2; k++) begin
            do_scan(1'b0, cx[k], cy[k], 1'b0, 1'b0);
            n_checks++;
            if (log_x.size() != 3 || log_x[0] != ex[k][0] || log_y[0] != ey[k][0] ||
                log_x[1] != ex[k][1] || log_y[1] != ey[k][1] ||
                log_x[2] != ex[k][2] || log_y[2] != ey[k][2]) begin
                n_errors++;
                $display("FAIL corner%0d_order: got %s expected (%0d,%0d)(%0d,%0d)(%0d,%0d)", k, q_str(1),
                         ex[k][0], ey[k][0], ex[k][1], ey[k][1], ex[k][2], ey[k][2]);
            end
            n_checks++;
            if (obs_cnt != 3) begin n_errors++; $display("FAIL corner%0d_cnt: got %0d expected 3", k, obs_cnt); end
            n_checks++;
            if (obs_lat != 12) begin n_errors++; $display("FAIL corner%0d_latency: got %0d expected 12", k, obs_lat); end
        end
    endtask

    task automatic test_torus_corner();
        int ex[8] = '{3, 0, 1, 3, 1, 3, 0, 1};
        int ey[8] = '{2, 2, 2, 0, 0, 1, 1, 1};
        bit ok;
        fill_mem(1);
        stall_req = -1;
        do_scan(1'b1, 0, 0, 1'b0, 1'b0);
        ok = (log_x.size() == 8);
        for (int i = 0; i < 8 && ok; i++) ok = (log_x[i] == ex[i]) && (log_y[i] == ey[i]);
        n_checks++;
        if (!ok) begin n_errors++; $display("FAIL torus_order: got %s expected (3,2)(0,2)(1,2)(3,0)(1,0)(3,1)(0,1)(1,1)", q_str(1)); end
        n_checks++;
        if (obs_cnt != 8) begin n_errors++; $display("FAIL torus_cnt: got %0d expected 8", obs_cnt); end
        n_checks++;
        if (obs_lat != 17) begin n_errors++; $display("FAIL torus_latency: got %0d expected 17", obs_lat); end
    endtask

    task automatic test_random_scans();
        stall_req = -1;
        for (int n = 0; n < 16; n++) begin
            bit s;
            int x, y;
            s = bit'($urandom_range(0, 1));
            x = int'($urandom_range(0, W - 1));
            y = int'($urandom_range(0, H - 1));
            fill_mem(2);
            build_model(s, x, y);
            do_scan(s, x, y, 1'b0, 1'b0);
            n_checks++;
            if (!order_ok()) begin n_errors++; $display("FAIL rand%0d_order torus=%0d cell(%0d,%0d): got %s expected %s", n, s, x, y, q_str(1), q_str(0)); end
            n_checks++;
            if (obs_cnt != exp_cnt) begin n_errors++; $display("FAIL rand%0d_cnt: got %0d expected %0d", n, obs_cnt, exp_cnt); end
            n_checks++;
            if (obs_lat != exp_lat) begin n_errors++; $display("FAIL rand%0d_latency: got %0d expected %0d", n, obs_lat, exp_lat); end
        end
    endtask

    // Stall on request 4 (E of an interior cell): ready low 3 cycles with
    // spurious rvalid meanwhile, rvalid 4 cycles after accept, plus a second
    // start while busy.
    task automatic test_stall();
        fill_mem(2);
        build_model(1'b0, 1, 1);
        stall_req   = 4;
        stall_left  = 3;
        stall_delay = 4;
        spurious    = 1'b1;
        do_scan(1'b0, 1, 1, 1'b0, 1'b1);
        spurious  = 1'b0;
        stall_req = -1;
        n_checks++;
        if (stab_err != 0) begin n_errors++; $display("FAIL stall_stable: got %0d changes expected 0", stab_err); end
        n_checks++;
        if (!order_ok()) begin n_errors++; $display("FAIL stall_order: got %s expected %s", q_str(1), q_str(0)); end
        n_checks++;
        if (obs_cnt != exp_cnt) begin n_errors++; $display("FAIL stall_cnt: got %0d expected %0d", obs_cnt, exp_cnt); end
        n_checks++;
        if (obs_lat != exp_lat + 6) begin n_errors++; $display("FAIL stall_latency: got %0d expected %0d", obs_lat, exp_lat + 6); end
    endtask

    task automatic test_reset_mid_wait();
        int  guard = 0;
        bit  done_seen = 1'b0;
        fill_mem(1);
        sel = 1'b0;
        log_x.delete();
        log_y.delete();
        req_num     = 0;
        stall_req   = 0;
        stall_left  = 0;
        stall_delay = 6;
        @(negedge clk);
        cell_x = 2'd1;
        cell_y = 2'd1;
        start_b = 1'b1;
        @(posedge clk);
        #1 start_b = 1'b0;
        while (req_num == 0 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        #2;
        n_checks++;
        if (req_num != 1 || busy_b !== 1'b1 || req_b !== 1'b0) begin
            n_errors++;
            $display("FAIL midwait_setup: reqs=%0d busy=%b req=%b expected 1 1 0", req_num, busy_b, req_b);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({req_b, busy_b, done_b, cnt_b, xa_b, ya_b} !== 11'd0) begin
            n_errors++;
            $display("FAIL midwait_reset_outputs: got %b expected 0", {req_b, busy_b, done_b, cnt_b, xa_b, ya_b});
        end
        repeat (3) begin
            @(negedge clk);
            done_seen |= done_b | done_t;
        end
        stall_req = -1;
        rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            done_seen |= done_b | done_t;
        end
        n_checks++;
        if (done_seen) begin n_errors++; $display("FAIL midwait_no_done: got done pulse expected none"); end
        fill_mem(2);
        build_model(1'b0, 2, 1);
        do_scan(1'b0, 2, 1, 1'b0, 1'b0);
        n_checks++;
        if (obs_cnt != exp_cnt) begin n_errors++; $display("FAIL midwait_rescan_cnt: got %0d expected %0d", obs_cnt, exp_cnt); end
        n_checks++;
        if (obs_lat != exp_lat) begin n_errors++; $display("FAIL midwait_rescan_latency: got %0d expected %0d", obs_lat, exp_lat); end
    endtask

`ifdef NBR_SCAN_LIFE_RULE_EN
    task automatic test_life_rule();
        int ks[6]     = '{3, 2, 2, 4, 8, 0};
        bit alives[6] = '{0, 1, 0, 1, 1, 1};
        stall_req = -1;
        for (int c = 0; c < 10; c++) begin
            int k;
            bit a, exp_next;
            k = (c < 6) ? ks[c] : int'($urandom_range(0, 8));
            a = (c < 6) ? alives[c] : bit'($urandom_range(0, 1));
            fill_mem(0);
            build_model(1'b0, 1, 1);
            for (int i = 0; i < k; i++) mem[exp_x[i]][exp_y[i]] = 1'b1;
            exp_next = (k == 3) || (k == 2 && a);
            do_scan(1'b0, 1, 1, a, 1'b0);
            n_checks++;
            if (obs_cnt != k) begin n_errors++; $display("FAIL life%0d_cnt: got %0d expected %0d", c, obs_cnt, k); end
            n_checks++;
            if (obs_next !== exp_next || obs_next2 !== exp_next) begin
                n_errors++;
                $display("FAIL life%0d_next cnt=%0d alive=%0d: got %b/%b expected %b", c, k, a, obs_next, obs_next2, exp_next);
            end
        end
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_interior();
        test_bounded_corners();
        test_torus_corner();
        test_random_scans();
        test_stall();
        test_reset_mid_wait();
`ifdef NBR_SCAN_LIFE_RULE_EN
        test_life_rule();
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/nbr_scan_counter.md
Name: nbr_scan_counter

Overview:
- Sequential successor to the combinational neighbour-address generator.
- For one target cell, it walks the 8 neighbours in fixed order (0..7: NW, N, NE, W, E, SW, S, SE) and reads each neighbour's state from field memory over a req/ready + rvalid handshake.
- It accumulates the live-neighbour count and pulses done.
- It sits between the generation controller and the field RAM. It supports bounded or toroidal edge handling.

Parameters:
- FIELD_W, 4, field width in cells (>=1)
- FIELD_H, 3, field height in cells (>=1)
- TORUS, 0, 0 = bounded (off-field neighbours skipped), 1 = toroidal wrap
- X_ADR_SIZE, $clog2(FIELD_W) (min 1), derived, not overridden
- Y_ADR_SIZE, $clog2(FIELD_H) (min 1), derived, not overridden

Ports:
- i_clk  in  1  clock, all logic on rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_start  in  1  start a scan; sampled only in IDLE
- i_cell_x_adr  in  X_ADR_SIZE  target cell x, latched on accepted start
- i_cell_y_adr  in  Y_ADR_SIZE  target cell y, latched on accepted start
- o_mem_req  out  1  read request valid
- o_mem_x_adr  out  X_ADR_SIZE  neighbour x address
- o_mem_y_adr  out  Y_ADR_SIZE  neighbour y address
- i_mem_ready  in  1  memory accepts request this cycle
- i_mem_rvalid  in  1  read data valid
- i_mem_rdata  in  1  neighbour cell state (1 = alive)
- o_busy  out  1  scan in progress (SCAN or WAIT)
- o_done  out  1  one-cycle pulse, count valid
- o_alive_cnt  out  4  live neighbours 0..8; held until next accepted start

Behaviour:
- Reset (async, i_rst_n=0): state=IDLE, idx=0, o_alive_cnt=0, o_mem_req=0, o_busy=0, o_done=0. Mem addresses are 0. Reset mid-scan aborts with no done pulse.
- States:
  - IDLE: i_start=1 latches addresses, sets idx=0 and count=0, goes to SCAN. o_alive_cnt is cleared on accept.
  - SCAN: if neighbour idx is relevant, assert o_mem_req with its address. Addresses are combinational from latched cell+idx. On i_mem_ready go to WAIT; else hold the request and address stable. If idx is not relevant, no request is issued and the cycle is spent skipping: idx==7 goes to DONE, else idx++.
  - WAIT: o_mem_req=0. On i_mem_rvalid, count += i_mem_rdata; then idx==7 goes to DONE, else idx++ and back to SCAN.
  - DONE: o_done=1 for exactly one cycle, then IDLE.
- One outstanding read max. i_mem_rvalid outside WAIT is ignored. i_start outside IDLE is ignored.
- Relevance and addresses:
  - TORUS=0: relevant iff x-1>=0 / x+1<=FIELD_W-1 / y-1>=0 / y+1<=FIELD_H-1 as applicable. Addresses are cell±1.
  - TORUS=1: all 8 relevant. x-1 at x=0 gives FIELD_W-1; x+1 at FIELD_W-1 gives 0; same for y. Non-power-of-2 sizes must wrap at FIELD_W/FIELD_H, not at 2^N.
  - TORUS=1 with FIELD_W==1 or FIELD_H==1: wrapped neighbour may be the cell itself or duplicated. It is read and counted as-is.
- Latency (ready=1, rvalid the cycle after accept): 2 cycles per relevant neighbour, 1 per skipped. Start sampled at cycle N: interior cell gives done at N+17; bounded corner (3 relevant) gives N+12.
- Counter is 4 bits and cannot overflow (max 8).

Optional Feature:
- Macro NBR_SCAN_LIFE_RULE_EN.
- When defined, add inputs i_cell_alive (latched on start) and output o_next_alive. o_next_alive is registered and updated together with o_done:
  - 1 if count==3
  - 1 if count==2 and cell alive
  - else 0
- Reset value 0, held until next done.
- When undefined, neither port exists and behaviour is otherwise identical.

Decomposition:
- Shared package life_pkg: NEIGHBOURS_CNT=8, neighbour index enum (NB_NW..NB_SE), and dx/dy offset constant arrays.
- Sub-module nbr_adr_calc: combinational (cell, idx) to (x, y, relevant) with TORUS parameter. It generalises the existing address generator. The FSM/counter stays in the top.

Test Plan:
- FIELD 4x3, TORUS=0, cell (1,1), all neighbours alive, ready=1, rvalid 1 cycle later -> 8 requests in order idx0..7, o_alive_cnt=8, o_done at N+17.
- TORUS=0, cell (0,0), memory returns 1 -> only E(1,0), S(0,1), SE(1,1) requested, count=3, done at N+12. Cell (3,2) -> NW, N, W only.
- TORUS=1, cell (0,0) -> first request (3,2), then (0,2),(1,2),(3,0),(1,0),(3,1),(0,1),(1,1); count=8 when all alive.
- i_mem_ready low 3 cycles and rvalid delayed 4 cycles on idx 4 -> req/address stable while stalled, count correct. Spurious rvalid in SCAN and extra i_start while busy -> ignored.
- Assert i_rst_n=0 mid-WAIT -> outputs immediately at reset values, no o_done. New start after release gives a correct count.
- NBR_SCAN_LIFE_RULE_EN: count 3/dead gives next=1; count 2/alive gives 1; count 2/dead gives 0; count 4/alive gives 0.
